// File: rtl/zeroriscy_defines.sv
// Shared types and constants for the writeback stage and load alignment.
package zeroriscy_defines;

    // Writeback FSM states.
    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

    // Load size encoding, identical to the LSU data_type encoding; 2'b11 behaves as a word.
    localparam logic [1:0] WB_TYPE_WORD = 2'b00;
    localparam logic [1:0] WB_TYPE_HALF = 2'b01;
    localparam logic [1:0] WB_TYPE_BYTE = 2'b10;

endpackage

// File: rtl/zeroriscy_load_align.sv
// Combinational load data alignment: rotate the word-aligned read data so the
// addressed byte lands in bits [7:0], then extract and extend to 32 bits.
module zeroriscy_load_align
    import zeroriscy_defines::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lsb,
    input  logic [1:0]  data_type,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] rotated;

    // Rotate right by 8*lsb; a half at lsb 11 therefore wraps byte 0 into [15:8].
    always_comb begin
        unique case (lsb)
            2'b00:   rotated = rdata;
            2'b01:   rotated = {rdata[7:0],  rdata[31:8]};
            2'b10:   rotated = {rdata[15:0], rdata[31:16]};
            default: rotated = {rdata[23:0], rdata[31:24]};
        endcase
    end

    // Extract the requested size and extend.
    always_comb begin
        unique case (data_type)
            WB_TYPE_BYTE: result = {{24{sign_ext & rotated[7]}}, rotated[7:0]};
            WB_TYPE_HALF: result = {{16{sign_ext & rotated[15]}}, rotated[15:0]};
            default:      result = rotated;
        endcase
    end

endmodule

// File: rtl/zeroriscy_wb_stage.sv
// Writeback stage: registers execute results, waits for load responses, aligns
// load data and drives the single register-file write port.
module zeroriscy_wb_stage
    import zeroriscy_defines::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              wb_ready_o,
    input  logic [31:0]       ex_wdata_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic              ex_we_i,
    input  logic              ex_is_load_i,
    input  logic [1:0]        ex_data_type_i,
    input  logic              ex_sign_ext_i,
    input  logic [1:0]        ex_addr_lsb_i,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_err_i,
    output logic              regfile_we_o,
    output logic [ADDR_W-1:0] regfile_waddr_o,
    output logic [31:0]       regfile_wdata_o,
    output logic              load_pending_o,
    output logic [ADDR_W-1:0] load_waddr_o,
    output logic              load_err_o,
    output logic              retire_o
);

    wb_state_e         state_q, state_d;

    logic [ADDR_W-1:0] ld_waddr_q;
    logic [1:0]        ld_type_q;
    logic              ld_sign_q;
    logic [1:0]        ld_lsb_q;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              retire_q, retire_d;
    logic              err_q, err_d;

    logic              accept;
    logic              resp;
    logic [31:0]       load_data;

    assign accept = ex_valid_i && (state_q == WB_IDLE);
    assign resp   = data_rvalid_i && (state_q == WB_WAIT_LOAD);

    zeroriscy_load_align u_load_align (
        .rdata     (data_rdata_i),
        .lsb       (ld_lsb_q),
        .data_type (ld_type_q),
        .sign_ext  (ld_sign_q),
        .result    (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE:      if (ex_valid_i && ex_is_load_i) state_d = WB_WAIT_LOAD;
            WB_WAIT_LOAD: if (data_rvalid_i) state_d = WB_IDLE;
            default:      state_d = WB_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        wb_ready_o     = (state_q == WB_IDLE);
        load_pending_o = (state_q == WB_WAIT_LOAD);
    end

    // Capture the load attributes on acceptance; held for the whole wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_waddr_q <= '0;
            ld_type_q  <= WB_TYPE_WORD;
            ld_sign_q  <= 1'b0;
            ld_lsb_q   <= 2'b00;
        end else if (accept && ex_is_load_i) begin
            ld_waddr_q <= ex_waddr_i;
            ld_type_q  <= ex_data_type_i;
            ld_sign_q  <= ex_sign_ext_i;
            ld_lsb_q   <= ex_addr_lsb_i;
        end
    end

    // Next write/retire/error values; pulses default low so they last one cycle.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        retire_d = 1'b0;
        err_d    = 1'b0;
        if (accept && !ex_is_load_i) begin
            we_d     = ex_we_i && (ex_waddr_i != '0);
            waddr_d  = ex_waddr_i;
            wdata_d  = ex_wdata_i;
            retire_d = 1'b1;
        end else if (resp) begin
            retire_d = 1'b1;
            if (data_err_i) begin
                err_d = 1'b1;
            end else begin
                we_d    = (ld_waddr_q != '0);
                waddr_d = ld_waddr_q;
                wdata_d = load_data;
            end
        end
    end

    // Write register and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            retire_q <= retire_d;
            err_q    <= err_d;
        end
    end

    assign regfile_we_o    = we_q;
    assign regfile_waddr_o = waddr_q;
    assign regfile_wdata_o = wdata_q;
    assign load_waddr_o    = ld_waddr_q;
    assign load_err_o      = err_q;
    assign retire_o        = retire_q;

endmodule

// File: tb/tb_zeroriscy_wb_stage.sv
// Self-checking bench for zeroriscy_wb_stage: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_zeroriscy_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        wb_ready_o;
    logic [31:0] ex_wdata_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_we_i;
    logic        ex_is_load_i;
    logic [1:0]  ex_data_type_i;
    logic        ex_sign_ext_i;
    logic [1:0]  ex_addr_lsb_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        regfile_we_o;
    logic [4:0]  regfile_waddr_o;
    logic [31:0] regfile_wdata_o;
    logic        load_pending_o;
    logic [4:0]  load_waddr_o;
    logic        load_err_o;
    logic        retire_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    zeroriscy_wb_stage #(.ADDR_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .wb_ready_o      (wb_ready_o),
        .ex_wdata_i      (ex_wdata_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_we_i         (ex_we_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_data_type_i  (ex_data_type_i),
        .ex_sign_ext_i   (ex_sign_ext_i),
        .ex_addr_lsb_i   (ex_addr_lsb_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i),
        .data_err_i      (data_err_i),
        .regfile_we_o    (regfile_we_o),
        .regfile_waddr_o (regfile_waddr_o),
        .regfile_wdata_o (regfile_wdata_o),
        .load_pending_o  (load_pending_o),
        .load_waddr_o    (load_waddr_o),
        .load_err_o      (load_err_o),
        .retire_o        (retire_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i     = 1'b0;
        ex_wdata_i     = '0;
        ex_waddr_i     = '0;
        ex_we_i        = 1'b0;
        ex_is_load_i   = 1'b0;
        ex_data_type_i = 2'b00;
        ex_sign_ext_i  = 1'b0;
        ex_addr_lsb_i  = 2'b00;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = '0;
        data_err_i     = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] waddr,
                            input logic [31:0] wdata, input logic retire, input logic err);
        chk({tag, ".we"}, regfile_we_o, we);
        if (we) begin
            chk({tag, ".waddr"}, regfile_waddr_o, waddr);
            chk({tag, ".wdata"}, regfile_wdata_o, wdata);
        end
        chk({tag, ".retire"}, retire_o, retire);
        chk({tag, ".err"}, load_err_o, err);
    endtask

    // Reference load result: rotate via a doubled word, mask to size, extend arithmetically.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] typ,
                                             input logic sgn, input logic [1:0] lsb);
        logic [63:0] dbl;
        logic [31:0] w, mask, v;
        int          nbytes;
        dbl    = {rdata, rdata} >> (8 * int'(lsb));
        w      = dbl[31:0];
        nbytes = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
        if (nbytes == 4) return w;
        mask = (32'd1 << (8 * nbytes)) - 32'd1;
        v    = w & mask;
        if (sgn && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    // Accept a load, wait gap cycles, respond, and check the resulting write/error.
    task automatic do_load(input string tag, input logic [4:0] dest, input logic [1:0] typ,
                           input logic sgn, input logic [1:0] lsb, input logic [31:0] rdata,
                           input logic err, input int gap, input logic [31:0] expd);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = dest;
        ex_data_type_i = typ; ex_sign_ext_i = sgn; ex_addr_lsb_i = lsb;
        chk({tag, ".ready_acc"}, wb_ready_o, 1'b1);
        tick();
        idle_inputs();
        for (int g = 0; g < gap; g++) begin
            chk({tag, ".ready_wait"}, wb_ready_o, 1'b0);
            chk({tag, ".pending"}, load_pending_o, 1'b1);
            chk({tag, ".ld_waddr"}, load_waddr_o, dest);
            check_wb({tag, ".wait"}, 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        data_rvalid_i = 1'b1; data_rdata_i = rdata; data_err_i = err;
        chk({tag, ".ready_resp"}, wb_ready_o, 1'b0);
        tick();
        idle_inputs();
        check_wb({tag, ".resp"}, !err && (dest != 0), dest, expd, 1'b1, err);
        chk({tag, ".ready_after"}, wb_ready_o, 1'b1);
        chk({tag, ".pending_after"}, load_pending_o, 1'b0);
        tick();
        check_wb({tag, ".quiet"}, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        m_pend;
        logic [4:0]  m_dest;
        logic [1:0]  m_type, m_lsb;
        logic        m_sign;
        logic        e_we, e_ret, e_err;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;

        // Reset state.
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_wb("reset", 1'b0, '0, '0, 1'b0, 1'b0);
        chk("reset.waddr", regfile_waddr_o, 32'd0);
        chk("reset.wdata", regfile_wdata_o, 32'd0);
        chk("reset.ready", wb_ready_o, 1'b1);
        chk("reset.pending", load_pending_o, 1'b0);
        chk("reset.ld_waddr", load_waddr_o, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back ALU results to x5..x7, then x0.
        for (int i = 0; i < 3; i++) begin
            ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'(5 + i);
            ex_wdata_i = 32'hA000_0000 + 32'(i);
            chk("alu.ready", wb_ready_o, 1'b1);
            tick();
            check_wb("alu", 1'b1, 5'(5 + i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        end
        ex_waddr_i = 5'd0; ex_wdata_i = 32'h1234_5678;
        tick();
        check_wb("alu_x0", 1'b0, '0, '0, 1'b1, 1'b0);
        idle_inputs();
        tick();
        check_wb("alu_hold", 1'b0, '0, '0, 1'b0, 1'b0);

        // Directed loads.
        do_load("lb_s", 5'd8, 2'b10, 1'b1, 2'b10, 32'h1280_3456, 1'b0, 2, 32'hFFFF_FF80);
        do_load("lhu", 5'd9, 2'b01, 1'b0, 2'b10, 32'h8001_1234, 1'b0, 1, 32'h0000_8001);
        do_load("lh_s", 5'd9, 2'b01, 1'b1, 2'b10, 32'h8001_1234, 1'b0, 0, 32'hFFFF_8001);
        do_load("lw", 5'd10, 2'b00, 1'b0, 2'b00, 32'hDEAD_BEEF, 1'b0, 1, 32'hDEAD_BEEF);
        do_load("lh_mis", 5'd11, 2'b01, 1'b0, 2'b11, 32'hAA00_00BB, 1'b0, 1, 32'h0000_BBAA);
        do_load("lerr", 5'd12, 2'b00, 1'b0, 2'b00, 32'hFFFF_FFFF, 1'b1, 1, 32'h0);

        // ALU held valid during a load wait: accepted the cycle after rvalid.
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd13;
        ex_data_type_i = 2'b00;
        tick();
        ex_is_load_i = 1'b0; ex_we_i = 1'b1; ex_waddr_i = 5'd14; ex_wdata_i = 32'h0BAD_CAFE;
        for (int g = 0; g < 2; g++) begin
            chk("hold.ready", wb_ready_o, 1'b0);
            chk("hold.ld_waddr", load_waddr_o, 32'd13);
            tick();
            check_wb("hold.wait", 1'b0, '0, '0, 1'b0, 1'b0);
        end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        chk("hold.ld_waddr_resp", load_waddr_o, 32'd13);
        tick();
        data_rvalid_i = 1'b0;
        check_wb("hold.load", 1'b1, 5'd13, 32'h5555_AAAA, 1'b1, 1'b0);
        chk("hold.ready_back", wb_ready_o, 1'b1);
        tick();
        idle_inputs();
        check_wb("hold.alu", 1'b1, 5'd14, 32'h0BAD_CAFE, 1'b1, 1'b0);
        tick();

        // Reset during a load wait, response arriving afterwards.
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd15;
        tick();
        idle_inputs();
        chk("rstw.pending", load_pending_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777; data_err_i = 1'b1;
        chk("rstw.ready", wb_ready_o, 1'b1);
        chk("rstw.pending0", load_pending_o, 1'b0);
        check_wb("rstw.after_rst", 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check_wb("rstw.resp_ignored", 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rstw.ready2", wb_ready_o, 1'b1);

        // Randomized traffic against the behavioural model.
        m_pend = 1'b0; m_dest = '0; m_type = '0; m_lsb = '0; m_sign = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ex_valid_i     = ($urandom_range(0, 3) != 0);
            ex_is_load_i   = ($urandom_range(0, 2) == 0);
            ex_we_i        = ($urandom_range(0, 4) != 0);
            ex_waddr_i     = 5'($urandom_range(0, 31));
            ex_wdata_i     = $urandom;
            ex_data_type_i = 2'($urandom_range(0, 3));
            ex_sign_ext_i  = 1'($urandom_range(0, 1));
            ex_addr_lsb_i  = 2'($urandom_range(0, 3));
            data_rvalid_i  = ($urandom_range(0, 2) == 0);
            data_rdata_i   = $urandom;
            data_err_i     = ($urandom_range(0, 7) == 0);

            chk("rnd.ready", wb_ready_o, !m_pend);
            chk("rnd.pending", load_pending_o, m_pend);
            if (m_pend) chk("rnd.ld_waddr", load_waddr_o, m_dest);

            e_we = 1'b0; e_ret = 1'b0; e_err = 1'b0; e_waddr = '0; e_wdata = '0;
            if (!m_pend) begin
                if (ex_valid_i && ex_is_load_i) begin
                    m_pend = 1'b1; m_dest = ex_waddr_i; m_type = ex_data_type_i;
                    m_sign = ex_sign_ext_i; m_lsb = ex_addr_lsb_i;
                end else if (ex_valid_i) begin
                    e_we = ex_we_i && (ex_waddr_i != 0);
                    e_waddr = ex_waddr_i; e_wdata = ex_wdata_i; e_ret = 1'b1;
                end
            end else if (data_rvalid_i) begin
                m_pend = 1'b0;
                e_ret  = 1'b1;
                if (data_err_i) begin
                    e_err = 1'b1;
                end else begin
                    e_we = (m_dest != 0); e_waddr = m_dest;
                    e_wdata = ref_load(data_rdata_i, m_type, m_sign, m_lsb);
                end
            end
            tick();
            check_wb("rnd", e_we, e_waddr, e_wdata, e_ret, e_err);
        end

        idle_inputs();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
